// File: rtl/intersection_scheduler.sv
// Purpose: shares one intersection between NS and EW; each grant runs FORWARD -> RIGHT -> LEFT -> OFF (clearance),
//          with demand-driven, round-robin arbitration and a writable bank of phase durations.
// Latency: all outputs registered; a request sampled in IDLE shows FORWARD (cnt = D_fwd) after the next edge; no dead cycles.
// Flow:    level requests, sampled only in IDLE and on the last clearance cycle; switch forces all-red while high.
// Ports:   clk, reset (sync, active-high), switch, req_ns/req_ew, cfg_we/cfg_sel/cfg_data (duration writes),
//          out_ns/out_ew (phase codes), cnt_ns/cnt_ew (cycles remaining), grant_ns/grant_ew.
// Option:  `define PREEMPT_EN adds emg_ns/emg_ew emergency inputs (preempt the other direction, freeze own FORWARD).
module intersection_scheduler #(
  parameter int CNT_W     = 8,
  parameter int DEF_FWD   = 15,
  parameter int DEF_RIGHT = 10,
  parameter int DEF_LEFT  = 10,
  parameter int DEF_OFF   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             switch,
  input  logic             req_ns,
  input  logic             req_ew,
`ifdef PREEMPT_EN
  input  logic             emg_ns,
  input  logic             emg_ew,
`endif
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [1:0]       out_ns,
  output logic [1:0]       out_ew,
  output logic [CNT_W-1:0] cnt_ns,
  output logic [CNT_W-1:0] cnt_ew,
  output logic             grant_ns,
  output logic             grant_ew
);

  // Phase codes double as the duration-bank index.
  localparam logic [1:0] PH_OFF   = 2'b00;
  localparam logic [1:0] PH_LEFT  = 2'b01;
  localparam logic [1:0] PH_FWD   = 2'b10;
  localparam logic [1:0] PH_RIGHT = 2'b11;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [3:0] {
    IDLE, NS_FWD, NS_RIGHT, NS_LEFT, NS_CLR, EW_FWD, EW_RIGHT, EW_LEFT, EW_CLR
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             last_ew, last_ew_nx;   // 1: EW was served last
  logic [CNT_W-1:0] dur     [4];
  logic [CNT_W-1:0] dur_eff [4];
  logic             pick_ns, pick_ew;
  logic             arb;

  logic [1:0]       out_ns_nx, out_ew_nx;
  logic [CNT_W-1:0] cnt_ns_nx, cnt_ew_nx;
  logic             grant_ns_nx, grant_ew_nx;

`ifdef PREEMPT_EN
  // A preemption remembers who must be granted once the forced clearance ends.
  logic pend, pend_nx;
  logic pend_ew, pend_ew_nx;
`endif

  // Shadow duration bank; switch does not touch it.
  always_ff @(posedge clk) begin
    if (reset) begin
      dur[PH_OFF]   <= CNT_W'(DEF_OFF);
      dur[PH_LEFT]  <= CNT_W'(DEF_LEFT);
      dur[PH_FWD]   <= CNT_W'(DEF_FWD);
      dur[PH_RIGHT] <= CNT_W'(DEF_RIGHT);
    end else if (cfg_we) begin
      dur[cfg_sel] <= cfg_data;
    end
  end

  // Duration a phase entering this cycle loads: a same-cycle write wins, and 0 is stretched to 1.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dur_eff[i] = (cfg_we && cfg_sel == 2'(i)) ? cfg_data : dur[i];
      if (dur_eff[i] == '0) dur_eff[i] = ONE;
    end
  end

  // Arbitration: a lone request wins; with both, serve the direction not served last.
  always_comb begin
    pick_ns = req_ns;
    pick_ew = req_ew;
    if (req_ns && req_ew) begin
      pick_ns = last_ew;
      pick_ew = !last_ew;
    end
`ifdef PREEMPT_EN
    if (pend) begin
      pick_ns = !pend_ew;
      pick_ew = pend_ew;
    end else if (emg_ns) begin
      pick_ns = 1'b1;
      pick_ew = 1'b0;
    end else if (emg_ew) begin
      pick_ns = 1'b0;
      pick_ew = 1'b1;
    end
`endif
  end

  // Next state / next count.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt - ONE;
    last_ew_nx = last_ew;
    arb        = 1'b0;
`ifdef PREEMPT_EN
    pend_nx    = pend;
    pend_ew_nx = pend_ew;
`endif
    case (state)
      IDLE:     arb = 1'b1;
      NS_FWD:   if (cnt == ONE) begin state_nx = NS_RIGHT; cnt_nx = dur_eff[PH_RIGHT]; end
      NS_RIGHT: if (cnt == ONE) begin state_nx = NS_LEFT;  cnt_nx = dur_eff[PH_LEFT];  end
      NS_LEFT:  if (cnt == ONE) begin state_nx = NS_CLR;   cnt_nx = dur_eff[PH_OFF];   end
      EW_FWD:   if (cnt == ONE) begin state_nx = EW_RIGHT; cnt_nx = dur_eff[PH_RIGHT]; end
      EW_RIGHT: if (cnt == ONE) begin state_nx = EW_LEFT;  cnt_nx = dur_eff[PH_LEFT];  end
      EW_LEFT:  if (cnt == ONE) begin state_nx = EW_CLR;   cnt_nx = dur_eff[PH_OFF];   end
      NS_CLR, EW_CLR: if (cnt == ONE) arb = 1'b1;
      default: begin state_nx = IDLE; cnt_nx = '0; end
    endcase

    // Same rule covers IDLE and end of clearance: the just-served direction is always `last`.
    if (arb) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      if (pick_ns) begin
        state_nx   = NS_FWD;
        cnt_nx     = dur_eff[PH_FWD];
        last_ew_nx = 1'b0;
      end else if (pick_ew) begin
        state_nx   = EW_FWD;
        cnt_nx     = dur_eff[PH_FWD];
        last_ew_nx = 1'b1;
      end
`ifdef PREEMPT_EN
      if (pick_ns || pick_ew) pend_nx = 1'b0;
`endif
    end

`ifdef PREEMPT_EN
    // NS emergency wins when both are raised.
    if (emg_ns) begin
      if (state == EW_FWD || state == EW_RIGHT || state == EW_LEFT) begin
        state_nx   = EW_CLR;
        cnt_nx     = dur_eff[PH_OFF];
        pend_nx    = 1'b1;
        pend_ew_nx = 1'b0;
      end else if (state == NS_FWD) begin
        state_nx = NS_FWD;
        cnt_nx   = cnt;
      end
    end else if (emg_ew) begin
      if (state == NS_FWD || state == NS_RIGHT || state == NS_LEFT) begin
        state_nx   = NS_CLR;
        cnt_nx     = dur_eff[PH_OFF];
        pend_nx    = 1'b1;
        pend_ew_nx = 1'b1;
      end else if (state == EW_FWD) begin
        state_nx = EW_FWD;
        cnt_nx   = cnt;
      end
    end
`endif

    if (switch) begin
      state_nx = IDLE;
      cnt_nx   = '0;
`ifdef PREEMPT_EN
      pend_nx  = 1'b0;
`endif
    end
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    out_ns_nx   = PH_OFF;
    out_ew_nx   = PH_OFF;
    grant_ns_nx = 1'b0;
    grant_ew_nx = 1'b0;
    case (state_nx)
      NS_FWD:   begin out_ns_nx = PH_FWD;   grant_ns_nx = 1'b1; end
      NS_RIGHT: begin out_ns_nx = PH_RIGHT; grant_ns_nx = 1'b1; end
      NS_LEFT:  begin out_ns_nx = PH_LEFT;  grant_ns_nx = 1'b1; end
      NS_CLR:   begin out_ns_nx = PH_OFF;   grant_ns_nx = 1'b1; end
      EW_FWD:   begin out_ew_nx = PH_FWD;   grant_ew_nx = 1'b1; end
      EW_RIGHT: begin out_ew_nx = PH_RIGHT; grant_ew_nx = 1'b1; end
      EW_LEFT:  begin out_ew_nx = PH_LEFT;  grant_ew_nx = 1'b1; end
      EW_CLR:   begin out_ew_nx = PH_OFF;   grant_ew_nx = 1'b1; end
      default:  ;
    endcase
    cnt_ns_nx = grant_ns_nx ? cnt_nx : '0;
    cnt_ew_nx = grant_ew_nx ? cnt_nx : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last_ew  <= 1'b1;
      out_ns   <= PH_OFF;
      out_ew   <= PH_OFF;
      cnt_ns   <= '0;
      cnt_ew   <= '0;
      grant_ns <= 1'b0;
      grant_ew <= 1'b0;
`ifdef PREEMPT_EN
      pend     <= 1'b0;
      pend_ew  <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      last_ew  <= last_ew_nx;
      out_ns   <= out_ns_nx;
      out_ew   <= out_ew_nx;
      cnt_ns   <= cnt_ns_nx;
      cnt_ew   <= cnt_ew_nx;
      grant_ns <= grant_ns_nx;
      grant_ew <= grant_ew_nx;
`ifdef PREEMPT_EN
      pend     <= pend_nx;
      pend_ew  <= pend_ew_nx;
`endif
    end
  end

endmodule
